// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the execute stage.
//   - ALU_OP_W / DATA_W : opcode and datapath widths (the ALU is fixed at 32)
//   - alu_op_t          : 4-bit opcode encoding
//   - REG_ZERO          : architectural zero register index (never forwarded)
//   - rol32()           : 32-bit rotate-left helper used by the ALU
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int DATA_W   = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_NOT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_ROL = 4'd10
    } alu_op_t;

    // Rotate left: shift a doubled copy so the bits falling off the top wrap
    // back in at the bottom; an amount of 0 returns the operand unchanged.
    function automatic logic [DATA_W-1:0] rol32(input logic [DATA_W-1:0] a,
                                                input logic [4:0]        amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {a, a} << amt;
        return dbl[2*DATA_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU.
//   op     : opcode (alu_op_t encoding); unused codes yield 0
//   a, b   : operands; shift/rotate amounts come from b[4:0]
//   result : wraps modulo 2^32, no flags
// ----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Opcode decode and datapath select.
    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            ALU_ROL: result = rol32(a, shamt);
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/exe_fwd_mux.sv
// ----------------------------------------------------------------------------
// exe_fwd_mux
// Combinational operand selector for one source register in EX.
// Priority (highest first): own EX/MEM output register, MEM stage, WB stage,
// latched register-file data. Register 0 always takes the latched data.
//   rs_addr / rf_data                         : source index and latched value
//   out_valid / out_rd_we / out_rd_addr / out_result : own output register
//   mem_we / mem_rd / mem_data                : MEM stage write-back
//   wb_we / wb_rd / wb_data                   : WB stage write-back
//   operand                                   : resolved value
// ----------------------------------------------------------------------------
module exe_fwd_mux #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic                  out_valid,
    input  logic                  out_rd_we,
    input  logic [REG_ADDR_W-1:0] out_rd_addr,
    input  logic [DATA_W-1:0]     out_result,
    input  logic                  mem_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     operand
);

    import alu_pkg::REG_ZERO;

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs_addr != REG_ADDR_W'(REG_ZERO));

    // Priority select: the youngest producer wins.
    always_comb begin
        operand = rf_data;
        if (rs_nonzero_s && out_valid && out_rd_we && (out_rd_addr == rs_addr)) begin
            operand = out_result;
        end else if (rs_nonzero_s && mem_we && (mem_rd == rs_addr)) begin
            operand = mem_data;
        end else if (rs_nonzero_s && wb_we && (wb_rd == rs_addr)) begin
            operand = wb_data;
        end else begin
            operand = rf_data;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage
// Execute pipeline stage between decode and memory.
//   clk, rst (async, active-high), flush (kills in-flight ops at next edge)
//   in_valid / in_ready + in_* : decoded op from decode
//   fwd_mem_* / fwd_wb_*       : later-stage write-backs for forwarding
//   out_valid / out_ready + out_result / out_rd_addr / out_rd_we : EX/MEM reg
// Two-deep: an EX register feeding the combinational ALU, then the EX/MEM
// output register. One op per cycle at full throughput.
// ----------------------------------------------------------------------------
module exe_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_alu_op,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [DATA_W-1:0]     in_rs2_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_rd_we,
    input  logic                  fwd_mem_we,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [DATA_W-1:0]     fwd_mem_data,
    input  logic                  fwd_wb_we,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0]     fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_rd_we
);

    import alu_pkg::ALU_OP_W;

    // EX register
    logic                  ex_v_r;
    logic [ALU_OP_W-1:0]   ex_alu_op_r;
    logic [REG_ADDR_W-1:0] ex_rs1_addr_r;
    logic [REG_ADDR_W-1:0] ex_rs2_addr_r;
    logic [DATA_W-1:0]     ex_rs1_data_r;
    logic [DATA_W-1:0]     ex_rs2_data_r;
    logic [DATA_W-1:0]     ex_imm_r;
    logic                  ex_use_imm_r;
    logic [REG_ADDR_W-1:0] ex_rd_addr_r;
    logic                  ex_rd_we_r;

    // EX/MEM output register
    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_result_r;
    logic [REG_ADDR_W-1:0] out_rd_addr_r;
    logic                  out_rd_we_r;

    // Handshake and datapath nets
    logic                  out_adv_s;
    logic                  ex_adv_s;
    logic                  in_ready_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;
    logic [DATA_W-1:0]     opa_s;
    logic [DATA_W-1:0]     rs2_res_s;
    logic [DATA_W-1:0]     opb_s;
    logic [DATA_W-1:0]     alu_res_s;

    // Pipeline handshake; reset and flush both close the input side.
    always_comb begin
        out_adv_s  = !out_valid_r || out_ready;
        ex_adv_s   = ex_v_r && out_adv_s;
        in_ready_s = !rst && !flush && (!ex_v_r || ex_adv_s);
        in_xfer_s  = in_valid && in_ready_s;
        out_xfer_s = out_valid_r && out_ready;
    end

    // Forwarding is re-evaluated every cycle, so a stalled op picks up
    // producers that arrive while it waits.
    exe_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .rs_addr     (ex_rs1_addr_r),
        .rf_data     (ex_rs1_data_r),
        .out_valid   (out_valid_r),
        .out_rd_we   (out_rd_we_r),
        .out_rd_addr (out_rd_addr_r),
        .out_result  (out_result_r),
        .mem_we      (fwd_mem_we),
        .mem_rd      (fwd_mem_rd),
        .mem_data    (fwd_mem_data),
        .wb_we       (fwd_wb_we),
        .wb_rd       (fwd_wb_rd),
        .wb_data     (fwd_wb_data),
        .operand     (opa_s)
    );

    exe_fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .rs_addr     (ex_rs2_addr_r),
        .rf_data     (ex_rs2_data_r),
        .out_valid   (out_valid_r),
        .out_rd_we   (out_rd_we_r),
        .out_rd_addr (out_rd_addr_r),
        .out_result  (out_result_r),
        .mem_we      (fwd_mem_we),
        .mem_rd      (fwd_mem_rd),
        .mem_data    (fwd_mem_data),
        .wb_we       (fwd_wb_we),
        .wb_rd       (fwd_wb_rd),
        .wb_data     (fwd_wb_data),
        .operand     (rs2_res_s)
    );

    // ALU operand B select.
    always_comb begin
        opb_s = rs2_res_s;
        if (ex_use_imm_r) begin
            opb_s = ex_imm_r;
        end else begin
            opb_s = rs2_res_s;
        end
    end

    alu u_alu (
        .op     (ex_alu_op_r),
        .a      (opa_s),
        .b      (opb_s),
        .result (alu_res_s)
    );

    // EX occupancy: flush wins over any capture or advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_r <= 1'b0;
        end else if (flush) begin
            ex_v_r <= 1'b0;
        end else if (in_xfer_s) begin
            ex_v_r <= 1'b1;
        end else if (ex_adv_s) begin
            ex_v_r <= 1'b0;
        end else begin
            ex_v_r <= ex_v_r;
        end
    end

    // EX payload capture; held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_alu_op_r   <= 4'd0;
            ex_rs1_addr_r <= {REG_ADDR_W{1'b0}};
            ex_rs2_addr_r <= {REG_ADDR_W{1'b0}};
            ex_rs1_data_r <= {DATA_W{1'b0}};
            ex_rs2_data_r <= {DATA_W{1'b0}};
            ex_imm_r      <= {DATA_W{1'b0}};
            ex_use_imm_r  <= 1'b0;
            ex_rd_addr_r  <= {REG_ADDR_W{1'b0}};
            ex_rd_we_r    <= 1'b0;
        end else if (in_xfer_s) begin
            ex_alu_op_r   <= in_alu_op;
            ex_rs1_addr_r <= in_rs1_addr;
            ex_rs2_addr_r <= in_rs2_addr;
            ex_rs1_data_r <= in_rs1_data;
            ex_rs2_data_r <= in_rs2_data;
            ex_imm_r      <= in_imm;
            ex_use_imm_r  <= in_use_imm;
            ex_rd_addr_r  <= in_rd_addr;
            ex_rd_we_r    <= in_rd_we;
        end else begin
            ex_alu_op_r   <= ex_alu_op_r;
            ex_rs1_addr_r <= ex_rs1_addr_r;
            ex_rs2_addr_r <= ex_rs2_addr_r;
            ex_rs1_data_r <= ex_rs1_data_r;
            ex_rs2_data_r <= ex_rs2_data_r;
            ex_imm_r      <= ex_imm_r;
            ex_use_imm_r  <= ex_use_imm_r;
            ex_rd_addr_r  <= ex_rd_addr_r;
            ex_rd_we_r    <= ex_rd_we_r;
        end
    end

    // EX/MEM output register. On flush the payload is left stale; consumers
    // must qualify out_rd_we with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= {DATA_W{1'b0}};
            out_rd_addr_r <= {REG_ADDR_W{1'b0}};
            out_rd_we_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r   <= 1'b0;
        end else if (ex_adv_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= alu_res_s;
            out_rd_addr_r <= ex_rd_addr_r;
            out_rd_we_r   <= ex_rd_we_r;
        end else if (out_xfer_s) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_result  = out_result_r;
    assign out_rd_addr = out_rd_addr_r;
    assign out_rd_we   = out_rd_we_r;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute pipeline stage that sits between decode and memory in the core.
- Accepts decoded ALU instructions over a valid/ready handshake and latches them into an EX register.
- In EX, resolves operand forwarding and drives the combinational ALU; the ALU result is registered into an EX/MEM output register with its own valid/ready handshake.
- Supports back-pressure, flush, and write-back metadata pass-through.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed at 32; only 32 is legal)
REG_ADDR_W, 5, register-file address width

Ports:
clk  input  1  stage clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  kill all in-flight ops (branch redirect)
in_valid  input  1  decode has an op
in_ready  output  1  stage can accept an op this cycle
in_alu_op  input  4  ALU opcode (alu_pkg encoding)
in_rs1_addr  input  REG_ADDR_W  source 1 register index
in_rs2_addr  input  REG_ADDR_W  source 2 register index
in_rs1_data  input  DATA_W  register-file read for rs1
in_rs2_data  input  DATA_W  register-file read for rs2
in_imm  input  DATA_W  sign-extended immediate
in_use_imm  input  1  1: ALU B = imm; 0: ALU B = rs2
in_rd_addr  input  REG_ADDR_W  destination register
in_rd_we  input  1  op writes rd
fwd_mem_we  input  1  MEM stage writes a register
fwd_mem_rd  input  REG_ADDR_W  MEM stage destination
fwd_mem_data  input  DATA_W  MEM stage value
fwd_wb_we  input  1  WB stage writes a register
fwd_wb_rd  input  REG_ADDR_W  WB stage destination
fwd_wb_data  input  DATA_W  WB stage value
out_valid  output  1  EX/MEM register holds a valid op
out_ready  input  1  MEM stage accepts
out_result  output  DATA_W  registered ALU result
out_rd_addr  output  REG_ADDR_W  registered destination
out_rd_we  output  1  registered write enable

Behaviour:
- Reset (async, active-high): ex_v=0, out_valid=0, out_result=0, out_rd_addr=0, out_rd_we=0, and all EX data registers cleared to 0. While rst=1, in_ready=0.
- Handshake rules:
  - out_adv = !out_valid || out_ready.
  - ex_adv = ex_v && out_adv.
  - in_ready = !flush && (!ex_v || ex_adv).
  - An input transfer occurs when in_valid && in_ready. The output transfer occurs when out_valid && out_ready.
- Latency: an op transferred at edge N appears on out_* after edge N+1 when there is no stall. Full throughput is one op per cycle.
- EX register: captures alu_op, rs1/rs2 addr+data, imm, use_imm, rd_addr, rd_we on an input transfer. It holds its contents while stalled (ex_v && !out_adv).
- Operand resolution happens combinationally in EX and is re-evaluated every cycle while stalled. Per source, in priority order:
  1. out register: out_valid && out_rd_we && out_rd_addr==rs && rs!=0
  2. MEM stage: fwd_mem_we && fwd_mem_rd==rs && rs!=0
  3. WB stage: fwd_wb_we && fwd_wb_rd==rs && rs!=0
  4. the latched register-file data
- Register 0 is never forwarded; its operand is always the latched data.
- ALU inputs: A = resolved rs1. B = in_use_imm ? imm : resolved rs2. The opcode passes through unchanged.
- ALU opcode semantics:
  - ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6 (~A).
  - SLL=7, SRL=8, SRA=9, ROL=10; shift and rotate amounts use B[4:0].
  - Codes 0 and 11–15 produce result 0 and still propagate a valid op.
  - ROL with amount 0 returns A.
  - Arithmetic wraps modulo 2^32; there are no flags.
- On ex_adv: out_result <= ALU result, out_rd_addr/out_rd_we <= EX copies, out_valid <= 1. Otherwise, if the output transfers, out_valid <= 0. Otherwise out_* hold.
- Flush (synchronous, takes effect at the next edge): ex_v <= 0 and out_valid <= 0. Any in_valid that cycle is dropped, because in_ready=0. Data registers may retain stale values, but out_rd_we must not be acted on while out_valid=0.
- Simultaneous events: flush beats every transfer. Output transfer and ex_adv in the same cycle constitute a normal pipeline move.
- Reset asserted mid-stall discards all ops immediately; no transfer completes during reset.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum (4-bit, encodings above);
  - ALU_OP_W=4 and DATA_W=32 constants;
  - REG_ZERO = 0.
- exe_stage instantiates the team's existing ALU module unchanged.
- One sub-module is natural: exe_fwd_mux, the combinational per-operand priority selector. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Basic op: ADD rs1=x1 (data 5), imm=7, use_imm=1, rd=x3 -> one cycle after the transfer: out_valid=1, out_result=12, out_rd_addr=3.
- Back-to-back dependency: ADD x3=x1+x2 (5+6), then SUB x4=x3-x1 with stale rs1 data 0 -> second op's result is 6, taken from the own-out forward.
- Priority and x0: out, MEM, and WB all target x5 with values 1, 2, 3 -> operand=1. With rs=x0 and every forward source targeting x0 carrying 9, the latched 0 is used.
- Back-pressure: out_ready=0 for 3 cycles while 3 ops are offered -> exactly 2 ops are held (out + EX), in_ready=0, and out_result is stable. Releasing out_ready yields the ops in order with no loss or duplication.
- Flush: flush pulsed with EX and out both valid and in_valid=1 -> next cycle out_valid=0, ex empty, and the offered op is not captured.
- ALU corners: SRA A=0x80000000 B=4 -> 0xF8000000. ROL A=0x80000001 B=0 -> 0x80000001. Opcode 0xF -> result 0 with out_valid=1. Async rst mid-stall -> out_valid drops immediately.
